// File: rtl/counter_ud_mode.sv
// Up/down event counter with run-time limit, programmable step and
// wrap / saturate / one-shot terminal behaviour with separate crossing pulses.
module counter_ud_mode #(
    parameter int          WIDTH   = 4,
    parameter int          STEP_W  = 2,
    parameter int unsigned RST_VAL = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              clr,
    input  logic              load_en,
    input  logic [WIDTH-1:0]  load,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic              rollover,
    output logic              underflow,
    output logic              at_limit,
    output logic              at_zero,
    output logic              halted
);

    localparam logic [WIDTH-1:0] RST_C = RST_VAL[WIDTH-1:0];

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_rollover;
    logic             r_underflow;
    logic             w_ro_nxt;
    logic             w_uf_nxt;

    // Arithmetic is one bit wider so limit+1 and count+step never alias.
    logic [WIDTH:0]   w_lim_x;
    logic [WIDTH:0]   w_lim1;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_up;
    logic [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_wrap_up;
    logic [WIDTH-1:0] w_wrap_dn;
    logic [WIDTH-1:0] w_load_clip;

    always_comb begin
        w_lim_x     = {1'b0, limit};
        w_lim1      = w_lim_x + 1'b1;
        w_step_x    = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
        w_s         = (w_step_x > w_lim1) ? w_lim1 : w_step_x;
        w_up        = {1'b0, r_count} + w_s;
        // The true results of these fit in WIDTH bits, so modular math is exact.
        w_dn        = r_count - w_s[WIDTH-1:0];
        w_wrap_up   = w_up[WIDTH-1:0] - w_lim1[WIDTH-1:0];
        w_wrap_dn   = r_count + w_lim1[WIDTH-1:0] - w_s[WIDTH-1:0];
        w_load_clip = (load > limit) ? limit : load;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_ro_nxt    = 1'b0;
        w_uf_nxt    = 1'b0;
        if (clr) begin
            w_count_nxt = RST_C;
            w_state_nxt = ST_RUN;
        end else if (load_en) begin
            w_count_nxt = w_load_clip;
            w_state_nxt = ST_RUN;
        end else if (en && (r_state == ST_RUN)) begin
            if (w_s == '0) begin
                w_count_nxt = r_count;
            end else if (r_count > limit) begin
                w_count_nxt = limit;
            end else if (!down) begin
                if (w_up <= w_lim_x) begin
                    w_count_nxt = w_up[WIDTH-1:0];
                end else begin
                    w_ro_nxt = 1'b1;
                    case (mode)
                        2'b01:   w_count_nxt = limit;
                        2'b10: begin
                            w_count_nxt = limit;
                            w_state_nxt = ST_HALT;
                        end
                        default: w_count_nxt = w_wrap_up;
                    endcase
                end
            end else begin
                if (w_s <= {1'b0, r_count}) begin
                    w_count_nxt = w_dn;
                end else begin
                    w_uf_nxt = 1'b1;
                    case (mode)
                        2'b01:   w_count_nxt = '0;
                        2'b10: begin
                            w_count_nxt = '0;
                            w_state_nxt = ST_HALT;
                        end
                        default: w_count_nxt = w_wrap_dn;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_RUN;
            r_count     <= RST_C;
            r_rollover  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_rollover  <= w_ro_nxt;
            r_underflow <= w_uf_nxt;
        end
    end

    assign count     = r_count;
    assign rollover  = r_rollover;
    assign underflow = r_underflow;
    assign at_limit  = (r_count == limit);
    assign at_zero   = (r_count == '0);
    assign halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_counter_ud_mode.sv
// Bench for counter_ud_mode: directed scenarios plus randomized traffic,
// all compared against an integer reference model.
module tb_counter_ud_mode;

    localparam int W  = 4;
    localparam int SW = 2;
    localparam int RV = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0, clr = 1'b0, load_en = 1'b0, down = 1'b0;
    logic [W-1:0]  load = '0, limit = '0;
    logic [SW-1:0] step = '0;
    logic [1:0]    mode = '0;
    logic [W-1:0]  count;
    logic          rollover, underflow, at_limit, at_zero, halted;
    logic [W+4:0]  obs;

    int total = 0;
    int bad   = 0;

    int m_cnt;
    bit m_halt, m_ro, m_uf;

    counter_ud_mode #(.WIDTH(W), .STEP_W(SW), .RST_VAL(RV)) dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .load_en(load_en),
        .load(load), .down(down), .step(step), .limit(limit), .mode(mode),
        .count(count), .rollover(rollover), .underflow(underflow),
        .at_limit(at_limit), .at_zero(at_zero), .halted(halted)
    );

    always #5 clk = ~clk;

    assign obs = {count, rollover, underflow, at_limit, at_zero, halted};

    function automatic logic [W+4:0] mexp();
        logic [W-1:0] c;
        c = W'(m_cnt);
        return {c, m_ro, m_uf, (m_cnt == int'(limit)), (m_cnt == 0), m_halt};
    endfunction

    task automatic model_reset();
        m_cnt = RV; m_halt = 0; m_ro = 0; m_uf = 0;
    endtask

    // Reference behaviour in plain integer arithmetic on the sampled inputs.
    task automatic model_edge();
        int lim, s, md;
        lim = int'(limit);
        md  = int'(mode);
        s   = (int'(step) > lim + 1) ? lim + 1 : int'(step);
        m_ro = 0; m_uf = 0;
        if (clr) begin
            m_cnt = RV; m_halt = 0;
        end else if (load_en) begin
            m_cnt = (int'(load) < lim) ? int'(load) : lim; m_halt = 0;
        end else if (en && !m_halt && s != 0) begin
            if (m_cnt > lim) m_cnt = lim;
            else if (!down) begin
                if (m_cnt + s <= lim) m_cnt = m_cnt + s;
                else begin
                    m_ro = 1;
                    if (md == 1) m_cnt = lim;
                    else if (md == 2) begin m_cnt = lim; m_halt = 1; end
                    else m_cnt = (m_cnt + s) % (lim + 1);
                end
            end else begin
                if (m_cnt >= s) m_cnt = m_cnt - s;
                else begin
                    m_uf = 1;
                    if (md == 1) m_cnt = 0;
                    else if (md == 2) begin m_cnt = 0; m_halt = 1; end
                    else m_cnt = ((m_cnt - s) % (lim + 1) + lim + 1) % (lim + 1);
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        total++;
        if (obs !== 9'b0011_00000) begin
            bad++; $display("FAIL reset_init: got %b want %b", obs, 9'b0011_00000);
        end
        rstn = 1'b1;
        limit = 4'd12; step = 2'd2; mode = 2'd0; down = 1'b0;
        load = 4'd7; load_en = 1'b1; cyc(); load_en = 1'b0;
        en = 1'b1; cyc();
        total++;
        if (count !== 4'd9 || obs !== mexp()) begin
            bad++; $display("FAIL reset_precount: got %b want cnt=9 model=%b", obs, mexp());
        end
        #2 rstn = 1'b0;
        #1;
        model_reset();
        total++;
        if (count !== 4'd3 || rollover !== 1'b0 || underflow !== 1'b0 || halted !== 1'b0) begin
            bad++; $display("FAIL reset_async: got cnt=%0d ro=%b uf=%b h=%b want cnt=3 ro=0 uf=0 h=0",
                            count, rollover, underflow, halted);
        end
        #1 rstn = 1'b1;
        en = 1'b0; clr = 1'b1; load_en = 1'b1; load = 4'd8; cyc();
        clr = 1'b0; load_en = 1'b0;
        total++;
        if (count !== 4'd3 || obs !== mexp()) begin
            bad++; $display("FAIL clr_over_load: got cnt=%0d obs=%b want cnt=3 model=%b", count, obs, mexp());
        end
    endtask

    task automatic test_wrap_up();
        int  ec[3] = '{9, 1, 3};
        bit  er[3] = '{0, 1, 0};
        limit = 4'd9; step = 2'd2; mode = 2'd0; down = 1'b0; en = 1'b0;
        load = 4'd7; load_en = 1'b1; cyc(); load_en = 1'b0;
        total++;
        if (count !== 4'd7) begin bad++; $display("FAIL wrap_up_load: got %0d want 7", count); end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (count !== W'(ec[i]) || rollover !== er[i] || obs !== mexp()) begin
                bad++; $display("FAIL wrap_up[%0d]: got cnt=%0d ro=%b obs=%b want cnt=%0d ro=%b model=%b",
                                i, count, rollover, obs, ec[i], er[i], mexp());
            end
        end
    endtask

    task automatic test_wrap_down();
        int ec[4] = '{8, 5, 2, 9};
        bit eu[4] = '{1, 0, 0, 1};
        limit = 4'd9; step = 2'd3; mode = 2'd0; down = 1'b1; en = 1'b0;
        load = 4'd1; load_en = 1'b1; cyc(); load_en = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (count !== W'(ec[i]) || underflow !== eu[i] || obs !== mexp()) begin
                bad++; $display("FAIL wrap_down[%0d]: got cnt=%0d uf=%b obs=%b want cnt=%0d uf=%b model=%b",
                                i, count, underflow, obs, ec[i], eu[i], mexp());
            end
        end
    endtask

    task automatic test_saturate();
        limit = 4'd12; step = 2'd3; mode = 2'd1; down = 1'b0; en = 1'b0;
        load = 4'd10; load_en = 1'b1; cyc(); load_en = 1'b0; en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            total++;
            if (count !== 4'd12 || rollover !== 1'b1 || obs !== mexp()) begin
                bad++; $display("FAIL sat_up[%0d]: got cnt=%0d ro=%b want cnt=12 ro=1", i, count, rollover);
            end
        end
        down = 1'b1; en = 1'b0; load = 4'd2; load_en = 1'b1; cyc(); load_en = 1'b0; en = 1'b1;
        cyc();
        total++;
        if (count !== 4'd0 || underflow !== 1'b1 || obs !== mexp()) begin
            bad++; $display("FAIL sat_down: got cnt=%0d uf=%b want cnt=0 uf=1", count, underflow);
        end
    endtask

    task automatic test_oneshot();
        int ec[4] = '{5, 5, 5, 5};
        bit er[4] = '{0, 1, 0, 0};
        bit eh[4] = '{0, 1, 1, 1};
        limit = 4'd5; step = 2'd1; mode = 2'd2; down = 1'b0; en = 1'b0;
        load = 4'd4; load_en = 1'b1; cyc(); load_en = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (count !== W'(ec[i]) || rollover !== er[i] || halted !== eh[i] || obs !== mexp()) begin
                bad++; $display("FAIL oneshot[%0d]: got cnt=%0d ro=%b h=%b want cnt=%0d ro=%b h=%b",
                                i, count, rollover, halted, ec[i], er[i], eh[i]);
            end
        end
        mode = 2'd0; cyc();
        total++;
        if (count !== 4'd5 || halted !== 1'b1 || rollover !== 1'b0) begin
            bad++; $display("FAIL oneshot_mode_chg: got cnt=%0d h=%b ro=%b want cnt=5 h=1 ro=0", count, halted, rollover);
        end
        load = 4'd2; load_en = 1'b1; cyc(); load_en = 1'b0;
        total++;
        if (count !== 4'd2 || halted !== 1'b0) begin
            bad++; $display("FAIL oneshot_release: got cnt=%0d h=%b want cnt=2 h=0", count, halted);
        end
        cyc();
        total++;
        if (count !== 4'd3 || obs !== mexp()) begin
            bad++; $display("FAIL oneshot_resume: got cnt=%0d want 3", count);
        end
    endtask

    task automatic test_edges();
        mode = 2'd0; down = 1'b0; step = 2'd1; limit = 4'd9; en = 1'b0;
        load = 4'd15; load_en = 1'b1; cyc(); load_en = 1'b0;
        total++;
        if (count !== 4'd9 || at_limit !== 1'b1) begin
            bad++; $display("FAIL load_clip: got cnt=%0d al=%b want cnt=9 al=1", count, at_limit);
        end
        limit = 4'd6; en = 1'b1; cyc();
        total++;
        if (count !== 4'd6 || rollover !== 1'b0 || underflow !== 1'b0 || obs !== mexp()) begin
            bad++; $display("FAIL limit_lower: got cnt=%0d ro=%b uf=%b want cnt=6 ro=0 uf=0", count, rollover, underflow);
        end
        step = 2'd0; cyc();
        total++;
        if (count !== 4'd6 || rollover !== 1'b0 || obs !== mexp()) begin
            bad++; $display("FAIL step_zero: got cnt=%0d ro=%b want cnt=6 ro=0", count, rollover);
        end
        limit = 4'd0; en = 1'b0; load = 4'd0; load_en = 1'b1; cyc(); load_en = 1'b0;
        step = 2'd1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (count !== 4'd0 || rollover !== 1'b1 || obs !== mexp()) begin
                bad++; $display("FAIL limit0_up[%0d]: got cnt=%0d ro=%b want cnt=0 ro=1", i, count, rollover);
            end
        end
        down = 1'b1; cyc();
        total++;
        if (count !== 4'd0 || underflow !== 1'b1 || rollover !== 1'b0 || obs !== mexp()) begin
            bad++; $display("FAIL limit0_down: got cnt=%0d uf=%b ro=%b want cnt=0 uf=1 ro=0", count, underflow, rollover);
        end
    endtask

    task automatic test_random();
        limit = 4'd10;
        for (int i = 0; i < 400; i++) begin
            clr     = ($urandom_range(0, 15) == 0);
            load_en = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            down    = 1'($urandom);
            step    = SW'($urandom);
            mode    = 2'($urandom);
            load    = W'($urandom);
            if ($urandom_range(0, 9) == 0) limit = W'($urandom);
            cyc();
            total++;
            if (obs !== mexp()) begin
                bad++; $display("FAIL random[%0d]: got {cnt,ro,uf,al,az,h}=%b want %b", i, obs, mexp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_oneshot();
        test_edges();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_ud_mode.md
Name: counter_ud_mode

Overview:
- Parametrised successor to the team's 4-bit up/down loadable counter.
- Adds run-time modulus (limit), programmable step, count enable and synchronous clear.
- Three terminal modes: wrap, saturate, one-shot. Separate overflow and underflow pulses.
- Used as a general event/timer counter driven from a cnt_if-style interface in block testbenches and datapaths.

Parameters:
- WIDTH, 4, count/load/limit width in bits (>=2).
- STEP_W, 2, width of step input (STEP_W <= WIDTH).
- RST_VAL, 0, count value after reset and after clr (must be <= 2**WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  count enable; count moves only when en=1.
- clr  input  1  synchronous clear to RST_VAL; highest synchronous priority.
- load_en  input  1  synchronous load of load value.
- load  input  WIDTH  load value.
- down  input  1  0=count up, 1=count down.
- step  input  STEP_W  increment/decrement amount per enabled cycle.
- limit  input  WIDTH  terminal value; count range is 0..limit.
- mode  input  2  00=wrap, 01=saturate, 10=one-shot, 11=reserved (behaves as wrap).
- count  output  WIDTH  current count (registered).
- rollover  output  1  one-cycle pulse: up-count crossed limit.
- underflow  output  1  one-cycle pulse: down-count crossed 0.
- at_limit  output  1  count==limit (combinational from registers).
- at_zero  output  1  count==0.
- halted  output  1  one-shot has terminated; counting frozen.

Behaviour:
- Reset (rstn=0, async): count=RST_VAL, rollover=0, underflow=0, halted=0. State=RUN.
- Priority each posedge: clr > load_en > en-count > hold. rollover/underflow default 0 every cycle (pulses last exactly one cycle).
- clr: count=RST_VAL, halted=0, no flags.
- load_en: count=min(load, limit), halted=0, no flags, regardless of en.
- Counting is evaluated only when en=1 and state=RUN. Arithmetic is done in WIDTH+1 bits, using s=min(step, limit+1).
- step=0: count holds, no flags.
- count>limit (limit lowered at run time) on an enabled cycle: count=limit, no flags, no step applied.
- Up, count+s<=limit: count+=s.
- Up, count+s>limit: rollover=1 next cycle. Wrap: count=count+s-(limit+1). Saturate: count=limit. One-shot: count=limit, state->HALT, halted=1.
- Down, s<=count: count-=s.
- Down, s>count: underflow=1 next cycle. Wrap: count=count+(limit+1)-s. Saturate: count=0. One-shot: count=0, state->HALT, halted=1.
- Saturate: once at a boundary, every further enabled step toward it re-asserts the flag each cycle (sticky-at-limit pulse train).
- Latency: count, rollover and underflow update on the same edge that samples en. at_limit and at_zero follow count with no extra delay.
- FSM, two states:
  - RUN -> HALT on one-shot terminal crossing.
  - HALT -> RUN on clr or load_en.
  - Mode change while HALT does not release it.
  - In HALT, en is ignored and count holds.
- limit=0: count is pinned at 0. Any nonzero enabled step flags (rollover for up, underflow for down). Wrap result is 0.
- Reset asserted mid-count or in HALT: immediate return to reset values, no flag emitted.

Test Plan:
- Reset/clear: WIDTH=4, RST_VAL=3. Assert rstn=0 mid-count at count=9 -> count=3, flags=0, halted=0 asynchronously. clr with load_en=1 -> count=3.
- Wrap up: limit=9, step=2, mode=00, load 7, en=1 -> count 7,9,1,3; rollover high only in the cycle count=1 appears.
- Wrap down: limit=9, step=3, down=1, load 1 -> 1,8,5,2,9; underflow pulse with count=8 and with count=9.
- Saturate: limit=12, step=3, up from 10 -> 10,12,12; rollover asserted on both saturating cycles. Then down=1, step=3 from 2 -> 0, underflow=1.
- One-shot: limit=5, step=1, up from 4 -> 5, 5 with rollover and halted=1; further en cycles hold 5, no pulses. load_en, load=2 -> count=2, halted=0, counting resumes.
- Edge cases:
  - load=15 with limit=9 -> count=9.
  - With count=9, lower limit to 6, en=1 -> count=6, no flags.
  - step=0 -> hold.
  - limit=0, up step=1 -> count 0, rollover every enabled cycle.
